bcd2bin_arbiter: RTL and testbench

BCD2BIN_ARBITER -- requirements
Module: bcd2bin_arbiter

---
 rtl/bcd2bin_arbiter_pkg.sv | 19 +
 rtl/bcd2bin_arbiter_rr_pick.sv | 30 +++
 rtl/bcd2bin_arbiter.sv | 154 +++++++++++++++
 tb/tb_bcd2bin_arbiter.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd2bin_arbiter_pkg.sv
// Shared types and constants for the BCD-to-binary conversion arbiter.
package bcd2bin_arbiter_pkg;

  localparam int unsigned BCD_W = 4;
  localparam int unsigned BIN_W = 7;
  localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  function automatic logic bcd_digit_ok(input logic [BCD_W-1:0] d);
    return d <= BCD_MAX;
  endfunction

endpackage

// File: rtl/bcd2bin_arbiter_rr_pick.sv
// Combinational round-robin picker: first asserted request at or after ptr_i.
module rr_pick #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [IDX_W-1:0]   idx_o
);

  logic        found;
  int unsigned pos;

  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    found   = 1'b0;
    pos     = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      pos = (32'(ptr_i) + k) % NUM_REQ;
      if (!found && req_i[IDX_W'(pos)]) begin
        found                 = 1'b1;
        grant_o[IDX_W'(pos)]  = 1'b1;
        idx_o                 = IDX_W'(pos);
      end
    end
  end

endmodule

// File: rtl/bcd2bin_arbiter.sv
// Arbitrates NUM_REQ requesters onto one BCD-to-binary converter, one request in flight.
module bcd2bin_arbiter
  import bcd2bin_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [BCD_W*NUM_REQ-1:0] req_bcd1,
  input  logic [BCD_W*NUM_REQ-1:0] req_bcd0,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic [NUM_REQ-1:0]       rsp_valid,
  output logic [BIN_W-1:0]         rsp_bin,
  output logic                     rsp_err,
  output logic                     conv_start,
  output logic [BCD_W-1:0]         conv_bcd1,
  output logic [BCD_W-1:0]         conv_bcd0,
  input  logic                     conv_ready,
  input  logic                     conv_done_tick,
  input  logic [BIN_W-1:0]         conv_bin
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CNT_W = $clog2(TIMEOUT);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]   gnt_q, gnt_d;
  logic [BCD_W-1:0]   bcd1_q, bcd1_d;
  logic [BCD_W-1:0]   bcd0_q, bcd0_d;
  logic [BIN_W-1:0]   bin_q, bin_d;
  logic               err_q, err_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [NUM_REQ-1:0] pick_grant;
  logic [IDX_W-1:0]   pick_idx;
  logic [BCD_W-1:0]   sel_bcd1, sel_bcd0;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .req_i   (req_valid),
    .ptr_i   (rr_ptr_q),
    .grant_o (pick_grant),
    .idx_o   (pick_idx)
  );

  // Digit mux for the requester the picker selected this cycle.
  always_comb begin
    sel_bcd1 = '0;
    sel_bcd0 = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_idx == IDX_W'(i)) begin
        sel_bcd1 = req_bcd1[i*BCD_W +: BCD_W];
        sel_bcd0 = req_bcd0[i*BCD_W +: BCD_W];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      gnt_q    <= '0;
      bcd1_q   <= '0;
      bcd0_q   <= '0;
      bin_q    <= '0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      gnt_q    <= gnt_d;
      bcd1_q   <= bcd1_d;
      bcd0_q   <= bcd0_d;
      bin_q    <= bin_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
    end
  end

  // Ready is gated by reset_n so nothing handshakes while reset is held.
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    gnt_d      = gnt_q;
    bcd1_d     = bcd1_q;
    bcd0_d     = bcd0_q;
    bin_d      = bin_q;
    err_d      = err_q;
    cnt_d      = cnt_q;
    req_ready  = '0;
    rsp_valid  = '0;
    conv_start = 1'b0;

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (reset_n) begin
          req_ready = pick_grant;
        end
        if (|req_valid) begin
          gnt_d  = pick_idx;
          bcd1_d = sel_bcd1;
          bcd0_d = sel_bcd0;
          if (!bcd_digit_ok(sel_bcd1) || !bcd_digit_ok(sel_bcd0)) begin
            bin_d   = '0;
            err_d   = 1'b1;
            state_d = RESP;
          end else begin
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        if (conv_ready) begin
          conv_start = 1'b1;
          cnt_d      = '0;
          state_d    = WAIT;
        end
      end
      WAIT: begin
        if (conv_done_tick) begin
          bin_d   = conv_bin;
          err_d   = 1'b0;
          state_d = RESP;
        end else if (cnt_q == CNT_LAST) begin
          bin_d   = '0;
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RESP: begin
        rsp_valid[gnt_q] = 1'b1;
        rr_ptr_d = (gnt_q == LAST_IDX) ? '0 : gnt_q + IDX_W'(1);
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign rsp_bin   = bin_q;
  assign rsp_err   = err_q;
  assign conv_bcd1 = bcd1_q;
  assign conv_bcd0 = bcd0_q;

endmodule

// File: tb/tb_bcd2bin_arbiter.sv
// Directed self-checking bench for bcd2bin_arbiter with a fixed-latency converter model.
module tb_bcd2bin_arbiter;

  localparam int unsigned N   = 4;
  localparam int unsigned TO  = 64;
  localparam int          LAT = 8;

  logic           clk = 1'b0;
  logic           reset_n;
  logic [N-1:0]   req_valid;
  logic [4*N-1:0] req_bcd1, req_bcd0;
  logic [N-1:0]   req_ready, rsp_valid;
  logic [6:0]     rsp_bin;
  logic           rsp_err, conv_start;
  logic [3:0]     conv_bcd1, conv_bcd0;
  logic           conv_ready, conv_done_tick;
  logic [6:0]     conv_bin;

  logic model_on, model_tick, stray_tick;
  int   m_cnt;
  int   n_start = 0;
  int   n_cmp = 0, n_bad = 0;
  int   n, s0, hits;

  always #5 clk = ~clk;

  assign conv_done_tick = model_tick | stray_tick;

  bcd2bin_arbiter #(.NUM_REQ(N), .TIMEOUT(TO)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .req_valid      (req_valid),
    .req_bcd1       (req_bcd1),
    .req_bcd0       (req_bcd0),
    .req_ready      (req_ready),
    .rsp_valid      (rsp_valid),
    .rsp_bin        (rsp_bin),
    .rsp_err        (rsp_err),
    .conv_start     (conv_start),
    .conv_bcd1      (conv_bcd1),
    .conv_bcd0      (conv_bcd0),
    .conv_ready     (conv_ready),
    .conv_done_tick (conv_done_tick),
    .conv_bin       (conv_bin)
  );

  // Converter model: done_tick LAT cycles after the conv_start cycle.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_cnt      <= 0;
      model_tick <= 1'b0;
      conv_bin   <= '0;
    end else begin
      model_tick <= 1'b0;
      if (model_on && conv_start) begin
        m_cnt    <= LAT - 1;
        conv_bin <= 7'(conv_bcd1 * 10 + conv_bcd0);
      end else if (m_cnt == 1) begin
        model_tick <= 1'b1;
        m_cnt      <= 0;
      end else if (m_cnt > 1) begin
        m_cnt <= m_cnt - 1;
      end
    end
  end

  always @(posedge clk) if (conv_start) n_start <= n_start + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [3:0] b1, input logic [3:0] b0);
    req_bcd1[i*4 +: 4] = b1;
    req_bcd0[i*4 +: 4] = b0;
  endtask

  task automatic wait_rsp(output int cnt);
    cnt = 0;
    while (rsp_valid == '0 && cnt < 200) begin
      step();
      cnt++;
    end
  endtask

  initial begin
    reset_n    = 1'b0;
    req_valid  = '0;
    req_bcd1   = '0;
    req_bcd0   = '0;
    conv_ready = 1'b1;
    model_on   = 1'b1;
    stray_tick = 1'b0;
    step();
    step();

    // Reset state, with requests present
    req_valid = 4'b1111;
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'h0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_rsp_bin", 32'(rsp_bin), 32'h0);
    chk("rst_rsp_err", 32'(rsp_err), 32'h0);
    chk("rst_conv_start", 32'(conv_start), 32'h0);
    chk("rst_conv_bcd1", 32'(conv_bcd1), 32'h0);
    chk("rst_conv_bcd0", 32'(conv_bcd0), 32'h0);
    req_valid = '0;
    step();
    reset_n = 1'b1;
    step();

    // Stray done tick in IDLE
    stray_tick = 1'b1;
    #1;
    chk("stray_rsp_now", 32'(rsp_valid), 32'h0);
    step();
    stray_tick = 1'b0;
    #1;
    chk("stray_rsp_next", 32'(rsp_valid), 32'h0);
    chk("stray_conv_start", 32'(conv_start), 32'h0);
    chk("idle_ready_none", 32'(req_ready), 32'h0);

    // Simultaneous req0 {5,5} and req2 {0,9}, rr_ptr=0
    set_req(0, 4'd5, 4'd5);
    set_req(2, 4'd0, 4'd9);
    req_valid = 4'b0101;
    #1;
    chk("sim_ready0", 32'(req_ready), 32'h1);
    step();
    req_valid[0] = 1'b0;
    #1;
    chk("sim_start0", 32'(conv_start), 32'h1);
    chk("sim_bcd1_0", 32'(conv_bcd1), 32'h5);
    chk("sim_bcd0_0", 32'(conv_bcd0), 32'h5);
    chk("sim_busy_ready", 32'(req_ready), 32'h0);
    wait_rsp(n);
    chk("sim_lat0", 32'(n), 32'(LAT + 1));
    chk("sim_rsp_valid0", 32'(rsp_valid), 32'h1);
    chk("sim_rsp_bin0", 32'(rsp_bin), 32'h37);
    chk("sim_rsp_err0", 32'(rsp_err), 32'h0);
    step();
    chk("sim_rsp_pulse0", 32'(rsp_valid), 32'h0);
    chk("sim_ready2", 32'(req_ready), 32'h4);
    step();
    req_valid[2] = 1'b0;
    #1;
    chk("sim_start2", 32'(conv_start), 32'h1);
    chk("sim_bcd0_2", 32'(conv_bcd0), 32'h9);
    wait_rsp(n);
    chk("sim_rsp_valid2", 32'(rsp_valid), 32'h4);
    chk("sim_rsp_bin2", 32'(rsp_bin), 32'h09);
    step();
    // rr_ptr should now be 3; probe without a handshake, then drop
    req_valid = 4'b1001;
    #1;
    chk("ptr3_ready", 32'(req_ready), 32'h8);
    req_valid = '0;
    #1;
    chk("drop_ready", 32'(req_ready), 32'h0);
    step();
    chk("drop_no_start", 32'(conv_start), 32'h0);

    // Single conversion req0 {9,9}
    s0 = n_start;
    set_req(0, 4'd9, 4'd9);
    req_valid = 4'b0001;
    #1;
    chk("one_ready", 32'(req_ready), 32'h1);
    step();
    req_valid = '0;
    #1;
    chk("one_start", 32'(conv_start), 32'h1);
    step();
    chk("one_start_pulse", 32'(conv_start), 32'h0);
    wait_rsp(n);
    chk("one_lat", 32'(n), 32'(LAT));
    chk("one_rsp_valid", 32'(rsp_valid), 32'h1);
    chk("one_rsp_bin", 32'(rsp_bin), 32'h63);
    chk("one_rsp_err", 32'(rsp_err), 32'h0);
    chk("one_start_count", 32'(n_start - s0), 32'h1);
    step();
    chk("one_rsp_pulse", 32'(rsp_valid), 32'h0);

    // Invalid digit on req1 (rr_ptr=1)
    s0 = n_start;
    set_req(1, 4'hA, 4'd3);
    req_valid = 4'b0010;
    #1;
    chk("inv_ready", 32'(req_ready), 32'h2);
    step();
    req_valid = '0;
    #1;
    chk("inv_rsp_valid", 32'(rsp_valid), 32'h2);
    chk("inv_rsp_err", 32'(rsp_err), 32'h1);
    chk("inv_rsp_bin", 32'(rsp_bin), 32'h0);
    step();
    chk("inv_rsp_pulse", 32'(rsp_valid), 32'h0);
    chk("inv_no_start", 32'(n_start - s0), 32'h0);

    // Timeout on req2 (rr_ptr=2), converter silent
    model_on = 1'b0;
    set_req(2, 4'd1, 4'd2);
    req_valid = 4'b0100;
    #1;
    chk("to_ready", 32'(req_ready), 32'h4);
    step();
    req_valid = '0;
    #1;
    chk("to_start", 32'(conv_start), 32'h1);
    wait_rsp(n);
    chk("to_lat", 32'(n), 32'(TO + 1));
    chk("to_rsp_valid", 32'(rsp_valid), 32'h4);
    chk("to_rsp_err", 32'(rsp_err), 32'h1);
    chk("to_rsp_bin", 32'(rsp_bin), 32'h0);
    model_on = 1'b1;
    step();
    set_req(3, 4'd4, 4'd2);
    req_valid = 4'b1000;
    #1;
    chk("after_to_ready", 32'(req_ready), 32'h8);
    step();
    req_valid = '0;
    wait_rsp(n);
    chk("after_to_lat", 32'(n), 32'(LAT + 1));
    chk("after_to_rsp_valid", 32'(rsp_valid), 32'h8);
    chk("after_to_rsp_bin", 32'(rsp_bin), 32'h2A);
    chk("after_to_rsp_err", 32'(rsp_err), 32'h0);
    step();

    // Reset while in WAIT
    set_req(0, 4'd3, 4'd3);
    req_valid = 4'b0001;
    step();
    req_valid = '0;
    step();
    step();
    reset_n = 1'b0;
    #1;
    chk("wrst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("wrst_rsp_bin", 32'(rsp_bin), 32'h0);
    chk("wrst_rsp_err", 32'(rsp_err), 32'h0);
    chk("wrst_conv_start", 32'(conv_start), 32'h0);
    chk("wrst_conv_bcd1", 32'(conv_bcd1), 32'h0);
    chk("wrst_conv_bcd0", 32'(conv_bcd0), 32'h0);
    chk("wrst_req_ready", 32'(req_ready), 32'h0);
    step();
    step();
    reset_n = 1'b1;
    hits = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (rsp_valid != '0) hits++;
    end
    chk("wrst_no_rsp", 32'(hits), 32'h0);
    set_req(0, 4'd9, 4'd0);
    req_valid = 4'b0001;
    #1;
    chk("wrst_ready", 32'(req_ready), 32'h1);
    step();
    req_valid = '0;
    wait_rsp(n);
    chk("wrst_lat", 32'(n), 32'(LAT + 1));
    chk("wrst_rsp_valid2", 32'(rsp_valid), 32'h1);
    chk("wrst_rsp_bin2", 32'(rsp_bin), 32'h5A);
    chk("wrst_rsp_err2", 32'(rsp_err), 32'h0);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
